// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage: owns the program counter, presents it to
// instruction memory combinationally and captures the returned word into the
// IF/ID pipeline register for decode.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   IMEM_WORDS  number of valid instruction words (bytes 0 .. IMEM_WORDS*4-1)
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous active-high reset
//   stall           hold PC and IF/ID this cycle
//   redirect        taken branch / jump this cycle (beats stall)
//   redirect_target byte address of the branch / jump target
//   instruction     word read combinationally from memory at address
//   address         current PC
//   if_id_instr     registered instruction for decode
//   if_id_pc_plus4  registered PC+4 of if_id_instr
//   if_id_valid     if_id_instr holds a real instruction (not a bubble)
//   fetch_count     number of valid instructions loaded into IF/ID
//   fault           sticky: a fetch was attempted outside the valid range
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        fault
);

  // The byte limit is held in 33 bits so a memory covering the whole 4 GiB
  // space cannot wrap the comparison.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;

  assign address  = pc;
  assign pc_plus4 = pc + 32'd4;
  assign in_range = ({1'b0, pc} < IMEM_BYTES);

  // Priority: reset > redirect > stall > out-of-range > normal fetch.
  // Redirect and out-of-range both insert a bubble; only an out-of-range
  // fetch freezes the PC and raises the sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= {RESET_PC[31:2], 2'b00};
      if_id_instr    <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'd0;
      fault          <= 1'b0;
    end else if (redirect) begin
      pc             <= {redirect_target[31:2], 2'b00};
      if_id_instr    <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (stall) begin
      pc             <= pc;
    end else if (!in_range) begin
      if_id_instr    <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      fault          <= 1'b1;
    end else begin
      pc             <= pc_plus4;
      if_id_instr    <= instruction;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage. Memory returns word i*4 at byte
// address i*4 (i.e. the word equals its address). Every driven cycle pushes
// the expected post-edge state onto a scoreboard queue that a monitor pops
// and compares one cycle later; scenario tasks add fixed-value checks.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 128;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instruction;
  logic [31:0] address;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        fault;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic [31:0] count;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .instruction(instruction),
    .address(address), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .fault(fault)
  );

  always #5 clk = ~clk;

  assign instruction = address;

  // Scoreboard monitor: compares the full DUT state one step after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({address, if_id_instr, if_id_pc_plus4, fetch_count, if_id_valid, fault} !== e) begin
        failures++;
        $display("[TB] FAIL scoreboard: got pc=%h instr=%h pcp4=%h cnt=%0d v=%b f=%b, want pc=%h instr=%h pcp4=%h cnt=%0d v=%b f=%b",
                 address, if_id_instr, if_id_pc_plus4, fetch_count, if_id_valid, fault,
                 e.pc, e.instr, e.pcp4, e.count, e.valid, e.fault);
      end
    end
  end

  // Drive one cycle, advance the reference model, push its expectation.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    @(negedge clk);
    reset = r; stall = s; redirect = d; redirect_target = t;
    if (r) begin
      m = '{pc: RESET_PC, instr: 32'd0, pcp4: 32'd0, count: 32'd0, valid: 1'b0, fault: 1'b0};
    end else if (d) begin
      m.pc = {t[31:2], 2'b00};
      m.instr = 32'd0; m.pcp4 = 32'd0; m.valid = 1'b0;
    end else if (s) begin
      m = m;
    end else if (m.pc >= IMEM_BYTES) begin
      m.instr = 32'd0; m.pcp4 = 32'd0; m.valid = 1'b0; m.fault = 1'b1;
    end else begin
      m.instr = m.pc;
      m.pcp4 = m.pc + 32'd4;
      m.pc = m.pc + 32'd4;
      m.valid = 1'b1;
      m.count = m.count + 32'd1;
    end
    sb.push_back(m);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0123);
    checks++;
    if (address !== RESET_PC || if_id_valid !== 1'b0 || fetch_count !== 32'd0 || fault !== 1'b0 || if_id_instr !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset: got pc=%h v=%b cnt=%0d f=%b instr=%h, want pc=%h v=0 cnt=0 f=0 instr=0",
               address, if_id_valid, fetch_count, fault, if_id_instr, RESET_PC);
    end
  endtask

  task automatic test_free_run;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (if_id_instr !== 32'd8 || if_id_pc_plus4 !== 32'd12 || address !== 32'd12 || fetch_count !== 32'd3 || if_id_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL free_run: got instr=%h pcp4=%h pc=%h cnt=%0d v=%b, want 8 c c 3 1",
               if_id_instr, if_id_pc_plus4, address, fetch_count, if_id_valid);
    end
  endtask

  task automatic test_stall;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      checks++;
      if (address !== 32'd8 || if_id_instr !== 32'd4 || if_id_pc_plus4 !== 32'd8 || fetch_count !== 32'd2) begin
        failures++;
        $display("[TB] FAIL stall_hold: got pc=%h instr=%h pcp4=%h cnt=%0d, want 8 4 8 2",
                 address, if_id_instr, if_id_pc_plus4, fetch_count);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (if_id_instr !== 32'd8 || address !== 32'd12) begin
      failures++;
      $display("[TB] FAIL stall_release: got instr=%h pc=%h, want 8 c", if_id_instr, address);
    end
  endtask

  task automatic test_redirect_stall;
    step(1'b0, 1'b1, 1'b1, 32'h0000_0023);
    checks++;
    if (address !== 32'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL redirect_stall: got pc=%h v=%b instr=%h pcp4=%h, want 20 0 0 0",
               address, if_id_valid, if_id_instr, if_id_pc_plus4);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (if_id_instr !== 32'h20 || if_id_pc_plus4 !== 32'h24) begin
      failures++;
      $display("[TB] FAIL redirect_resume: got instr=%h pcp4=%h, want 20 24", if_id_instr, if_id_pc_plus4);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] cnt;
    step(1'b0, 1'b0, 1'b1, 32'h0000_01FC);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    cnt = m.count;
    checks++;
    if (if_id_instr !== 32'h1FC || if_id_valid !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL last_word: got instr=%h v=%b f=%b, want 1fc 1 0", if_id_instr, if_id_valid, fault);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      checks++;
      if (address !== 32'h200 || fault !== 1'b1 || if_id_valid !== 1'b0 || fetch_count !== cnt) begin
        failures++;
        $display("[TB] FAIL out_of_range: got pc=%h f=%b v=%b cnt=%0d, want 200 1 0 %0d",
                 address, fault, if_id_valid, fetch_count, cnt);
      end
    end
  endtask

  task automatic test_fault_recovery;
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (if_id_instr !== 32'd0 || if_id_valid !== 1'b1 || address !== 32'd4 || fault !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fault_recovery: got instr=%h v=%b pc=%h f=%b, want 0 1 4 1",
               if_id_instr, if_id_valid, address, fault);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fault_clear: got f=%b, want 0", fault);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    checks++;
    if (address !== RESET_PC || if_id_instr !== 32'd0 || if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b0 || fetch_count !== 32'd0 || fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got pc=%h instr=%h pcp4=%h v=%b cnt=%0d f=%b, want all reset values",
               address, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, fault);
    end
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (if_id_instr !== RESET_PC || if_id_pc_plus4 !== RESET_PC + 32'd4 || if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL first_fetch: got instr=%h pcp4=%h v=%b cnt=%0d, want %h %h 1 1",
               if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count, RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] t;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 540);
      step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), t);
    end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_stall;
    test_redirect_stall;
    test_out_of_range;
    test_fault_recovery;
    test_reset_mid;
    test_back_to_back;
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128, meaning the number of valid instruction words; the valid byte range is 0 to IMEM_WORDS*4-1.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  hold the PC and the IF/ID register this cycle.
REQ-006 Redirect  input  1  taken branch or jump this cycle.
REQ-007 RedirectTarget  input  32  byte address of the branch or jump target.
REQ-008 Instruction  input  32  word returned combinationally by instruction memory for Address.
REQ-009 Address  output  32  current PC, driven combinationally to instruction memory.
REQ-010 IfId_Instr  output  32  registered instruction handed to decode.
REQ-011 IfId_PCPlus4  output  32  registered PC+4 of the instruction in IfId_Instr.
REQ-012 IfId_Valid  output  1  IfId_Instr holds a real instruction, not a bubble.
REQ-013 FetchCount  output  32  count of valid instructions loaded into IF/ID.
REQ-014 Fault  output  1  sticky flag: a fetch was attempted outside the valid range.

Function
REQ-015 Address SHALL equal the PC register at all times, with no added latency.
REQ-016 An instruction SHALL appear on IfId_Instr one cycle after its PC is on Address, provided no stall or redirect occurs.
REQ-017 Normal cycle (no Stall, no Redirect, PC in range) SHALL update state as follows:
- PC <= PC+4, modulo 2^32.
- IfId_Instr <= Instruction.
- IfId_PCPlus4 <= PC+4.
- IfId_Valid <= 1.
- FetchCount <= FetchCount+1, wrapping at 2^32.
REQ-018 Stall=1 with Redirect=0 SHALL hold PC, IfId_Instr, IfId_PCPlus4, IfId_Valid and FetchCount unchanged.
REQ-019 Redirect=1 SHALL take priority over Stall and SHALL update state as follows:
- PC <= {RedirectTarget[31:2], 2'b00}; target bits [1:0] are ignored.
- IfId_Instr <= 0, IfId_Valid <= 0, IfId_PCPlus4 <= 0 (bubble).
- FetchCount unchanged.
REQ-020 Out-of-range fetch SHALL be detected when PC >= IMEM_WORDS*4 and Stall=0 and Redirect=0; it SHALL cause:
- a bubble loaded into IF/ID;
- Fault <= 1;
- PC held (no advance);
- FetchCount unchanged.
REQ-021 Fault SHALL remain 1 until Reset; a Redirect to an in-range target SHALL resume fetching while Fault stays 1.
REQ-022 The PC SHALL be aligned out of reset and after every redirect, and SHALL never hold nonzero bits [1:0].
REQ-023 Priority per edge SHALL be: Reset > Redirect > Stall > out-of-range > normal.

Reset
REQ-024 Reset=1 at a rising edge SHALL set:
- PC = RESET_PC;
- IfId_Instr = 0, IfId_PCPlus4 = 0, IfId_Valid = 0;
- FetchCount = 0, Fault = 0.
REQ-025 Reset SHALL override Stall and Redirect asserted in the same cycle, and SHALL abort any stall in progress with no state retained.
REQ-026 On the first edge after Reset deasserts, IF/ID SHALL load the word at RESET_PC.

Verification
REQ-027 Free run: Reset 1 cycle, memory[i]=i*4, 3 edges -> IfId_Instr=8, IfId_PCPlus4=12, Address=12, FetchCount=3, IfId_Valid=1.
REQ-028 Stall: Stall=1 for 2 edges while PC=8 -> Address stays 8 and IF/ID unchanged; on release, the next edge loads Instr=8 and PC becomes 12.
REQ-029 Redirect with Stall: Stall=1, Redirect=1, RedirectTarget=32'h23 in one cycle -> next Address=32'h20, IfId_Valid=0, IfId_Instr=0; the following edge gives IfId_Instr=32'h20, IfId_PCPlus4=32'h24.
REQ-030 Out of range: IMEM_WORDS=128, redirect to 32'h1FC and run 2 edges -> first edge loads Instr=32'h1FC valid; second edge gives Address held at 32'h200, Fault=1, IfId_Valid=0, FetchCount unchanged.
REQ-031 Fault recovery: redirect to 0 after the fault -> fetching resumes from 0 with Fault still 1; Reset clears Fault to 0.
REQ-032 Reset mid-operation: assert Reset while Stall=1 and PC=40 -> next edge gives Address=RESET_PC and all outputs at their reset values.
